// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Drives an external 1-bit full adder so that two WIDTH-bit operands are added
// one bit per clock, LSB first. One operation takes WIDTH cycles in ADD. The
// result then waits in HOLD until the consumer takes it.
//
//   IDLE --(start_valid)--> ADD --(WIDTH bits done)--> HOLD --(done_ready)--> IDLE
//
// Ports
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   start_valid/ready : operand request handshake (ready only in IDLE)
//   a_in, b_in, cin_in: operands and carry-in, sampled only when accepted
//   fa_a, fa_b, fa_cin: bit drives to the external full adder (0 outside ADD)
//   fa_sum, fa_cout   : full-adder results, consumed on each ADD edge
//   sum_out, cout_out : registered result, held until the next completion
//   done_valid/ready  : result handshake (valid only in HOLD)
//   busy              : high in ADD or HOLD
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps CNT_W >= 1.
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] a_sh_q,     a_sh_d;
  logic [WIDTH-1:0] b_sh_q,     b_sh_d;
  logic [WIDTH-1:0] sum_sh_q,   sum_sh_d;
  logic             carry_q,    carry_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [WIDTH-1:0] sum_out_q,  sum_out_d;
  logic             cout_out_q, cout_out_d;

  logic in_add;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-value default before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_sh_d   = sum_sh_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    sum_out_d  = sum_out_q;
    cout_out_d = cout_out_q;

    case (state_q)
      ST_IDLE: begin
        // start_ready is 1 throughout IDLE, so start_valid alone accepts.
        if (start_valid) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = cin_in;
          sum_sh_d = '0;
          cnt_d    = '0;
          state_d  = ST_ADD;
        end
      end

      ST_ADD: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        // Sum enters at the MSB, so after WIDTH shifts bit 0 sits at bit 0.
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Publish the shifted-in value directly; sum_sh_q is one bit short.
          sum_out_d  = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_out_d = fa_cout;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // No acceptance on the leaving edge: the request waits one IDLE cycle.
        if (done_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all of these are plain flops (no memory arrays), so they are all
      // reset; an aborted operation leaves nothing behind.
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      sum_out_q  <= '0;
      cout_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      sum_out_q  <= sum_out_d;
      cout_out_q <= cout_out_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decoded from registers only, so reset clears them at once and
  // the full-adder drives never depend on fa_sum/fa_cout (no comb loop).
  // -------------------------------------------------------------------------
  assign in_add      = (state_q == ST_ADD);
  assign start_ready = (state_q == ST_IDLE);
  assign done_valid  = (state_q == ST_HOLD);
  assign busy        = (state_q == ST_ADD) || (state_q == ST_HOLD);

  assign fa_a   = in_add & a_sh_q[0];
  assign fa_b   = in_add & b_sh_q[0];
  assign fa_cin = in_add & carry_q;

  assign sum_out  = sum_out_q;
  assign cout_out = cout_out_q;

endmodule
